conv_window_mac: RTL and testbench
==================================

Name: conv_window_mac

Overview:
- Consumes the nine 3x3 window taps produced by the line buffer and computes one signed fixed-point convolution result per valid window position.
- Tracks column/row position from the same `shifting` strobe that drives the line buffer. Suppresses windows that straddle a row wrap or the top two rows.
- Pipelines multiply, add-tree and round/saturate. Emits `out_data`/`out_valid` and a `frame_done` pulse.

Parameters:
- DATA_W, 16, pixel/weight width; equals `WID_LINE.
- ADDR_W, 10, row/column counter width; equals `ADDR_FIFO.
- ACC_W, 2*DATA_W+4, accumulator width.
- SHIFT_W, 5, output shift amount width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- shifting  in  1  same strobe driving the line buffer; one pixel accepted per high cycle.
- window_reset  in  1  synchronous frame restart; tied to line_buffer_reset.
- row_length  in  ADDR_W  pixels per row.
- col_height  in  ADDR_W  rows per frame.
- in1..in9  in  DATA_W each  window taps, signed. in1 = newest pixel; in5 = centre; in9 = oldest (two rows, two columns back).
- weights  in  9*DATA_W  signed; tap k occupies bits [k*DATA_W-1:(k-1)*DATA_W] and multiplies in_k.
- bias  in  ACC_W  signed; added before rounding.
- out_shift  in  SHIFT_W  arithmetic right shift applied to the result.
- out_data  out  DATA_W  signed saturated result.
- out_valid  out  1  out_data qualifier, single-cycle per result.
- frame_done  out  1  one-cycle pulse coincident with the last out_valid of a frame.

Behaviour:
- Reset (rst low, async): counters, pipeline valids, out_data, out_valid and frame_done all 0.
- Position counters col, row (ADDR_W): on each shifting cycle, col increments. When col == row_length-1, col wraps to 0 and row increments. When row == col_height-1 and col wraps, row wraps to 0.
- Window validity: computed from the pre-increment (col,row) of the shifting cycle. win_ok = (col >= 2) && (row >= 2).
- Tap sampling: the line buffer updates its outputs on the edge ending the shifting cycle. The taps are sampled one cycle later: a registered copy of shifting gates stage-1 capture, with win_ok delayed alongside it.
- Stage 1: nine signed DATA_W x DATA_W products, registered at 2*DATA_W.
- Stage 2: three partial sums of three products, registered, sign-extended to ACC_W.
- Stage 3 arithmetic:
  - s = p0+p1+p2+bias.
  - If out_shift > 0, add 1<<(out_shift-1) (round half up), then arithmetic shift right by out_shift.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Register into out_data.
- Latency: out_valid rises exactly 4 cycles after the shifting cycle that completed the window (1 sample + 3 pipeline). Throughput is 1 result/cycle. There is no backpressure.
- out_data holds its last value while out_valid is low.
- frame_done asserts with out_valid when the source window was at col == row_length-1 and row == col_height-1.
- Degenerate size: row_length < 3 or col_height < 3 means win_ok is never true. No out_valid and no frame_done are produced, and there is no lockup.
- window_reset high:
  - col and row cleared.
  - All in-flight pipeline valid bits and frame_done flags cleared the same cycle.
  - out_data is not cleared.
  - If shifting is simultaneously high, that pixel is discarded (reset wins).
- Quasi-static inputs: weights, bias, out_shift, row_length and col_height must be stable for the whole frame. The block does not register them beyond pipeline use.
- Async reset mid-frame: identical to power-on reset. The next frame requires window_reset or starts at col=row=0.

Decomposition:
- Shared package conv_pkg holds:
  - DATA_W/ACC_W localparams derived from header macros.
  - A typedef for signed pixel, product and accumulator.
  - The saturate/round function, reused by future pooling stages.
- One natural sub-module: conv_pos_counter (col/row counters, win_ok, last-pixel flag). The MAC pipeline stays in the top.

Test Plan:
1. Identity kernel: w5=1, others 0, bias 0, shift 0. 5x5 frame, pixel p(r,c)=5r+c, shifting continuous. Required: out_data sequence 6,7,8,11,12,13,16,17,18; exactly 9 out_valid; frame_done with the 18; first out_valid 4 cycles after the 13th shifting cycle.
2. All-ones kernel on the same frame. Required: 54,63,72,99,108,117,144,153,162.
3. Saturation: all taps 32767, all weights 32767, shift 0. Required: 32767. Weights all -32768 with taps 32767: required -32768.
4. Rounding, identity kernel, shift=1: in5=5 gives 3; in5=-5 gives -2. With bias=4 and in5=5, shift=1: 5.
5. window_reset asserted on the 15th pixel of the 5x5 frame with results in flight. Required: no out_valid for 4 cycles after the reset cycle. A restarted full frame then reproduces scenario 1 exactly.
6. row_length=2, col_height=5, 10 shifting pulses. Required: out_valid and frame_done never assert. Then a gapped shifting pattern (1 on, 2 off) on a 5x5 frame gives the same 9 values as scenario 1.

Source files
------------

// File: rtl/conv_window_mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared widths, signed datapath types and the round/saturate
//                helper for the 3x3 convolution MAC and later pooling stages.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef WID_LINE
`define WID_LINE 16
`endif
`ifndef ADDR_FIFO
`define ADDR_FIFO 10
`endif

package conv_pkg;

    localparam int DATA_W  = `WID_LINE;
    localparam int ADDR_W  = `ADDR_FIFO;
    localparam int PROD_W  = 2*DATA_W;
    localparam int ACC_W   = 2*DATA_W + 4;
    localparam int SHIFT_W = 5;
    localparam int N_TAPS  = 9;

    typedef logic signed [DATA_W-1:0] pix_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    // Round half up, arithmetic shift right, then clamp to the pixel range.
    // One guard bit keeps the rounding add from wrapping near full scale.
    function automatic pix_t round_sat(input acc_t s, input logic [SHIFT_W-1:0] sh);
        logic signed [ACC_W:0] t;
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] maxv;
        logic signed [ACC_W:0] minv;
        maxv = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
        minv = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
        t    = {s[ACC_W-1], s};
        if (sh != '0) begin
            rnd = {{ACC_W{1'b0}}, 1'b1} << (sh - 1'b1);
            t   = t + rnd;
            t   = t >>> sh;
        end
        if (t > maxv) begin
            return maxv[DATA_W-1:0];
        end else if (t < minv) begin
            return minv[DATA_W-1:0];
        end
        return t[DATA_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_window_mac_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_mac_if
//  Description : Pixel-side bus of the convolution MAC: shift strobe, frame
//                restart, the nine window taps and the result stream.
//                master = window source / result sink, slave = MAC.
//  Revision    : 1.0 - initial release
// ============================================================================
interface conv_window_mac_if;
    import conv_pkg::*;

    logic shifting;
    logic window_reset;
    pix_t in1, in2, in3, in4, in5, in6, in7, in8, in9;
    pix_t out_data;
    logic out_valid;
    logic frame_done;

    modport master (
        output shifting, window_reset,
        output in1, in2, in3, in4, in5, in6, in7, in8, in9,
        input  out_data, out_valid, frame_done
    );

    modport slave (
        input  shifting, window_reset,
        input  in1, in2, in3, in4, in5, in6, in7, in8, in9,
        output out_data, out_valid, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/conv_window_mac_pos_counter.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pos_counter
//  Description : Column/row position of the pixel being shifted into the line
//                buffer. win_ok and last_pix describe the current (pre-
//                increment) position and are meant to be sampled with the
//                same shifting strobe.
//  Ports       : clk, rst_n (async, active low), shifting, window_reset,
//                row_length, col_height -> win_ok, last_pix
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_pos_counter #(
    parameter int ADDR_W = conv_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shifting,
    input  logic              window_reset,
    input  logic [ADDR_W-1:0] row_length,
    input  logic [ADDR_W-1:0] col_height,
    output logic              win_ok,
    output logic              last_pix
);
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic              col_wrap;
    logic              row_wrap;

    always_comb begin
        col_wrap = (col_q == row_length - 1'b1);
        row_wrap = (row_q == col_height - 1'b1);
        col_d    = col_q;
        row_d    = row_q;
        // Restart wins over a coincident shift: that pixel is dropped.
        if (window_reset) begin
            col_d = '0;
            row_d = '0;
        end else if (shifting) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = row_wrap ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // A full 3x3 neighbourhood exists only from the third column/row on.
    assign win_ok   = (col_q >= ADDR_W'(2)) && (row_q >= ADDR_W'(2));
    assign last_pix = col_wrap && row_wrap;
endmodule
`default_nettype wire

// File: rtl/conv_window_mac.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_mac
//  Description : 3x3 signed fixed-point convolution over line-buffer taps.
//                Taps are sampled one cycle after the shifting cycle, then
//                multiply / add-tree / round-saturate stages follow; a result
//                appears 4 cycles after the pixel that completed the window.
//  Ports       : clk, rst_n (async, active low)
//                bus (slave): shifting, window_reset, in1..in9 ->
//                             out_data, out_valid, frame_done
//                row_length, col_height : frame geometry (quasi-static)
//                weights, bias, out_shift : kernel setup (quasi-static)
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_window_mac #(
    parameter int DATA_W  = conv_pkg::DATA_W,
    parameter int ADDR_W  = conv_pkg::ADDR_W,
    parameter int ACC_W   = 2*DATA_W + 4,
    parameter int SHIFT_W = conv_pkg::SHIFT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    conv_window_mac_if.slave         bus,
    input  logic [ADDR_W-1:0]        row_length,
    input  logic [ADDR_W-1:0]        col_height,
    input  logic [9*DATA_W-1:0]      weights,
    input  logic signed [ACC_W-1:0]  bias,
    input  logic [SHIFT_W-1:0]       out_shift
);
    import conv_pkg::*;

    localparam int P_W = 2*DATA_W;

    logic win_ok;
    logic last_pix;

    conv_pos_counter #(.ADDR_W(ADDR_W)) u_pos (
        .clk          (clk),
        .rst_n        (rst_n),
        .shifting     (bus.shifting),
        .window_reset (bus.window_reset),
        .row_length   (row_length),
        .col_height   (col_height),
        .win_ok       (win_ok),
        .last_pix     (last_pix)
    );

    logic signed [DATA_W-1:0] tap [9];
    logic signed [DATA_W-1:0] wgt [9];

    assign tap[0] = bus.in1;
    assign tap[1] = bus.in2;
    assign tap[2] = bus.in3;
    assign tap[3] = bus.in4;
    assign tap[4] = bus.in5;
    assign tap[5] = bus.in6;
    assign tap[6] = bus.in7;
    assign tap[7] = bus.in8;
    assign tap[8] = bus.in9;

    for (genvar k = 0; k < 9; k++) begin : g_wgt
        assign wgt[k] = $signed(weights[k*DATA_W +: DATA_W]);
    end

    // Sample stage: taps become valid the cycle after the shift.
    logic shift_q, shift_d, win_q, win_d, last_q, last_d;
    // Stage 1 / 2 / 3 control and data.
    logic v1_q, v1_d, fd1_q, fd1_d;
    logic v2_q, v2_d, fd2_q, fd2_d;
    logic out_valid_q, out_valid_d, frame_done_q, frame_done_d;
    logic signed [P_W-1:0]    prod_q [9];
    logic signed [P_W-1:0]    prod_d [9];
    logic signed [ACC_W-1:0]  psum_q [3];
    logic signed [ACC_W-1:0]  psum_d [3];
    logic signed [ACC_W-1:0]  sum_w;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;

    always_comb begin
        // window_reset kills every in-flight valid/frame flag this cycle.
        shift_d = bus.shifting & ~bus.window_reset;
        win_d   = win_ok;
        last_d  = last_pix;

        v1_d  = shift_q & win_q & ~bus.window_reset;
        fd1_d = shift_q & win_q & last_q & ~bus.window_reset;
        prod_d = prod_q;
        if (shift_q & win_q) begin
            for (int k = 0; k < 9; k++) begin
                prod_d[k] = P_W'(tap[k]) * P_W'(wgt[k]);
            end
        end

        v2_d   = v1_q & ~bus.window_reset;
        fd2_d  = fd1_q & ~bus.window_reset;
        psum_d = psum_q;
        if (v1_q) begin
            for (int j = 0; j < 3; j++) begin
                psum_d[j] = ACC_W'(prod_q[3*j]) + ACC_W'(prod_q[3*j+1])
                          + ACC_W'(prod_q[3*j+2]);
            end
        end

        sum_w        = psum_q[0] + psum_q[1] + psum_q[2] + bias;
        out_valid_d  = v2_q & ~bus.window_reset;
        frame_done_d = fd2_q & ~bus.window_reset;
        // out_data is only updated by a result; it is never cleared by restart.
        out_data_d   = out_data_q;
        if (out_valid_d) begin
            out_data_d = round_sat(sum_w, out_shift);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q      <= 1'b0;
            win_q        <= 1'b0;
            last_q       <= 1'b0;
            v1_q         <= 1'b0;
            fd1_q        <= 1'b0;
            v2_q         <= 1'b0;
            fd2_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_data_q   <= '0;
        end else begin
            shift_q      <= shift_d;
            win_q        <= win_d;
            last_q       <= last_d;
            v1_q         <= v1_d;
            fd1_q        <= fd1_d;
            v2_q         <= v2_d;
            fd2_q        <= fd2_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            out_data_q   <= out_data_d;
        end
    end

    // Datapath registers carry no reset; their valids qualify them.
    always_ff @(posedge clk) begin
        prod_q <= prod_d;
        psum_q <= psum_d;
    end

    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;
endmodule
`default_nettype wire

// File: tb/tb_conv_window_mac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_window_mac
//  Description : Directed self-checking bench for conv_window_mac. Models the
//                line buffer tap update and compares results, latency and
//                frame_done against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_conv_window_mac;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0]       row_length;
    logic [ADDR_W-1:0]       col_height;
    logic [9*DATA_W-1:0]     weights;
    logic signed [ACC_W-1:0] bias;
    logic [SHIFT_W-1:0]      out_shift;

    conv_window_mac_if bus();

    conv_window_mac #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .row_length (row_length),
        .col_height (col_height),
        .weights    (weights),
        .bias       (bias),
        .out_shift  (out_shift)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Result monitor.
    longint mon_data[$];
    int     mon_cyc[$];
    bit     mon_fd[$];
    int     fd_cnt = 0;
    int     sh_cyc[$];

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.out_valid === 1'b1) begin
                mon_data.push_back(longint'(bus.out_data));
                mon_cyc.push_back(cyc);
                mon_fd.push_back(bus.frame_done === 1'b1);
            end
            if (bus.frame_done === 1'b1) fd_cnt++;
        end
    end

    function automatic int pv(input int r, input int c, input int cols);
        if (r < 0 || c < 0) return 0;
        return r*cols + c;
    endfunction

    // Line buffer view after pixel (r,c) was shifted in.
    task automatic set_taps(input int r, input int c, input int cols);
        bus.in1 = pix_t'(pv(r,   c,   cols));
        bus.in2 = pix_t'(pv(r,   c-1, cols));
        bus.in3 = pix_t'(pv(r,   c-2, cols));
        bus.in4 = pix_t'(pv(r-1, c,   cols));
        bus.in5 = pix_t'(pv(r-1, c-1, cols));
        bus.in6 = pix_t'(pv(r-1, c-2, cols));
        bus.in7 = pix_t'(pv(r-2, c,   cols));
        bus.in8 = pix_t'(pv(r-2, c-1, cols));
        bus.in9 = pix_t'(pv(r-2, c-2, cols));
    endtask

    task automatic set_const_taps(input int a[9]);
        bus.in1 = pix_t'(a[0]); bus.in2 = pix_t'(a[1]); bus.in3 = pix_t'(a[2]);
        bus.in4 = pix_t'(a[3]); bus.in5 = pix_t'(a[4]); bus.in6 = pix_t'(a[5]);
        bus.in7 = pix_t'(a[6]); bus.in8 = pix_t'(a[7]); bus.in9 = pix_t'(a[8]);
    endtask

    task automatic set_w(input int w[9]);
        for (int k = 0; k < 9; k++) weights[k*DATA_W +: DATA_W] = DATA_W'(w[k]);
    endtask

    task automatic start_frame(input int rl, input int ch);
        @(negedge clk);
        row_length       = ADDR_W'(rl);
        col_height       = ADDR_W'(ch);
        bus.shifting     = 1'b0;
        bus.window_reset = 1'b1;
        @(negedge clk);
        bus.window_reset = 1'b0;
        mon_data.delete(); mon_cyc.delete(); mon_fd.delete();
        fd_cnt = 0;
    endtask

    // Shift pixels, one per (gap+1) cycles; abort_at >= 0 raises
    // window_reset together with that pixel and stops there.
    task automatic drive_frame(input int rows, input int cols, input int gap,
                               input int abort_at, input bit const_taps);
        int n;
        int k;
        int t;
        bit pend;
        int pr;
        int pc;
        n = (abort_at >= 0) ? abort_at + 1 : rows*cols;
        k = 0; t = 0; pend = 1'b0; pr = 0; pc = 0;
        sh_cyc.delete();
        while (k < n) begin
            @(negedge clk);
            if (pend && !const_taps) set_taps(pr, pc, cols);
            pend = 1'b0;
            bus.window_reset = 1'b0;
            if (t % (gap + 1) == 0) begin
                bus.shifting = 1'b1;
                sh_cyc.push_back(cyc);
                pr = k / cols; pc = k % cols; pend = 1'b1;
                if (k == abort_at) bus.window_reset = 1'b1;
                k++;
            end else begin
                bus.shifting = 1'b0;
            end
            t++;
        end
        @(negedge clk);
        bus.shifting = 1'b0;
        bus.window_reset = 1'b0;
        if (pend && !const_taps) set_taps(pr, pc, cols);
        repeat (8) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input longint exp[$],
                               input int rows, input int cols);
        int vidx[$];
        int n;
        for (int k = 0; k < rows*cols; k++)
            if (k / cols >= 2 && k % cols >= 2) vidx.push_back(k);
        check({tag, "_count"}, mon_data.size(), exp.size());
        n = (mon_data.size() < exp.size()) ? mon_data.size() : exp.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i), mon_data[i], exp[i]);
            check($sformatf("%s_lat%0d", tag, i), mon_cyc[i], sh_cyc[vidx[i]] + 4);
            check($sformatf("%s_fd%0d", tag, i), mon_fd[i], (i == exp.size() - 1) ? 1 : 0);
        end
        check({tag, "_fdcnt"}, fd_cnt, 1);
    endtask

    task automatic run_single(input string tag, input int a[9], input int w[9],
                              input int b, input int sh, input longint expv);
        longint e[$];
        e.push_back(expv);
        set_w(w);
        bias      = ACC_W'(b);
        out_shift = SHIFT_W'(sh);
        set_const_taps(a);
        start_frame(3, 3);
        drive_frame(3, 3, 0, -1, 1'b1);
        check_frame(tag, e, 3, 3);
    endtask

    longint exp_id[$];
    longint exp_ones[$];
    int w_id[9];
    int w_ones[9];
    int w_max[9];
    int w_min[9];
    int a_max[9];
    int a_p5[9];
    int a_m5[9];
    int rst_cyc;
    int late;

    initial begin
        exp_id   = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
        exp_ones = '{54, 63, 72, 99, 108, 117, 144, 153, 162};
        for (int k = 0; k < 9; k++) begin
            w_id[k]   = (k == 4) ? 1 : 0;
            w_ones[k] = 1;
            w_max[k]  = 32767;
            w_min[k]  = -32768;
            a_max[k]  = 32767;
            a_p5[k]   = (k == 4) ? 5 : 0;
            a_m5[k]   = (k == 4) ? -5 : 0;
        end

        rst_n = 1'b0;
        bus.shifting = 1'b0;
        bus.window_reset = 1'b0;
        set_const_taps(a_p5);
        set_w(w_id);
        bias = '0;
        out_shift = '0;
        row_length = ADDR_W'(5);
        col_height = ADDR_W'(5);
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_out_data", longint'(bus.out_data), 0);
        rst_n = 1'b1;

        // Identity kernel on a 5x5 ramp.
        start_frame(5, 5);
        drive_frame(5, 5, 0, -1, 1'b0);
        check_frame("ident", exp_id, 5, 5);
        check("hold_data", longint'(bus.out_data), 18);
        check("hold_valid", bus.out_valid, 0);

        // All-ones kernel.
        set_w(w_ones);
        start_frame(5, 5);
        drive_frame(5, 5, 0, -1, 1'b0);
        check_frame("ones", exp_ones, 5, 5);

        // Saturation and rounding on single-window frames.
        run_single("sat_pos", a_max, w_max, 0, 0, 32767);
        run_single("sat_neg", a_max, w_min, 0, 0, -32768);
        run_single("rnd_p5", a_p5, w_id, 0, 1, 3);
        run_single("rnd_m5", a_m5, w_id, 0, 1, -2);
        run_single("rnd_bias", a_p5, w_id, 4, 1, 5);

        // Restart on pixel 15 with results in flight.
        set_w(w_id);
        bias = '0;
        out_shift = '0;
        start_frame(5, 5);
        drive_frame(5, 5, 0, 14, 1'b0);
        rst_cyc = sh_cyc[14];
        late = 0;
        foreach (mon_cyc[i]) if (mon_cyc[i] > rst_cyc && mon_cyc[i] <= rst_cyc + 4) late++;
        check("abort_quiet", late, 0);
        check("abort_total", mon_data.size(), 0);
        check("abort_fd", fd_cnt, 0);
        start_frame(5, 5);
        drive_frame(5, 5, 0, -1, 1'b0);
        check_frame("restart", exp_id, 5, 5);

        // Degenerate width: never a window.
        start_frame(2, 5);
        drive_frame(5, 2, 0, -1, 1'b0);
        check("degen_valid", mon_data.size(), 0);
        check("degen_fd", fd_cnt, 0);

        // Gapped shifting: 1 on, 2 off.
        start_frame(5, 5);
        drive_frame(5, 5, 2, -1, 1'b0);
        check_frame("gapped", exp_id, 5, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
